// File: rtl/cue_pkg.sv
// rtl/cue_pkg.sv - shared state encoding and level width for the cue shot path
package cue_pkg;

  localparam int LVL_W       = 5;
  localparam int DEF_MAX_LVL = 11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARMED    = 3'd1,
    ST_SWING    = 3'd2,
    ST_HOLD     = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

endpackage

// File: rtl/cue_shot_controller_if.sv
// rtl/cue_shot_controller_if.sv - game-side signal bundle for the cue shot controller
interface cue_shot_controller_if;
  import cue_pkg::*;

  logic             arm;
  logic [LVL_W-1:0] speed_level;
  logic             level_valid;
  logic             shot_ack;
  logic             sample_en;
  logic             shot_valid;
  logic [LVL_W-1:0] shot_power;
  logic [2:0]       state;
  logic             timeout;

  // Game/physics side: drives arm, levels and ack; observes the shot
  modport master (
    output arm, speed_level, level_valid, shot_ack,
    input  sample_en, shot_valid, shot_power, state, timeout
  );

  // Controller side
  modport slave (
    input  arm, speed_level, level_valid, shot_ack,
    output sample_en, shot_valid, shot_power, state, timeout
  );

endinterface

// File: rtl/sample_divider.sv
// rtl/sample_divider.sv - free-running divider emitting a one-cycle sample strobe
module sample_divider #(
  parameter int SAMPLE_DIV = 9
) (
  input  logic clk,
  input  logic rst_n,
  output logic sample_en
);

  localparam int DIV_W = $clog2(SAMPLE_DIV + 1);

  logic [DIV_W-1:0] r_div;
  logic             r_sample_en;

  // Count 0..SAMPLE_DIV-1 and register the strobe on the terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div       <= '0;
      r_sample_en <= 1'b0;
    end else begin
      r_sample_en <= (r_div == DIV_W'(SAMPLE_DIV - 1));
      if (r_div == DIV_W'(SAMPLE_DIV - 1)) begin
        r_div <= '0;
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  assign sample_en = r_sample_en;

endmodule

// File: rtl/cue_shot_controller.sv
// rtl/cue_shot_controller.sv - swing detection, peak capture and shot handshake
module cue_shot_controller
  import cue_pkg::*;
#(
  parameter int SAMPLE_DIV       = 9,
  parameter int START_LVL        = 4,
  parameter int END_LVL          = 2,
  parameter int QUIET_SAMPLES    = 3,
  parameter int MAX_SWING        = 32,
  parameter int COOLDOWN_SAMPLES = 16,
  parameter int MAX_LVL          = DEF_MAX_LVL
) (
  input logic                  clk,
  input logic                  rst_n,
  cue_shot_controller_if.slave shot_if
);

  localparam int QW = $clog2(QUIET_SAMPLES + 1);
  localparam int SW = $clog2(MAX_SWING + 1);
  localparam int CW = $clog2(COOLDOWN_SAMPLES + 1);

  state_t           r_state;
  logic [LVL_W-1:0] r_peak;
  logic [QW-1:0]    r_quiet_cnt;
  logic [SW-1:0]    r_swing_cnt;
  logic [CW-1:0]    r_cd_cnt;
  logic             r_shot_valid;
  logic [LVL_W-1:0] r_shot_power;
  logic             r_timeout;

  logic             w_sample_en;
  logic [LVL_W-1:0] w_lvl;
  logic [LVL_W-1:0] w_peak_next;
  logic [QW-1:0]    w_quiet_next;
  logic [SW-1:0]    w_swing_next;
  logic [CW-1:0]    w_cd_next;

  sample_divider #(
    .SAMPLE_DIV(SAMPLE_DIV)
  ) u_sample_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .sample_en(w_sample_en)
  );

  // Clamp the incoming level and precompute the per-sample counter updates
  always_comb begin
    w_lvl        = (shot_if.speed_level > LVL_W'(MAX_LVL)) ? LVL_W'(MAX_LVL) : shot_if.speed_level;
    w_peak_next  = (w_lvl > r_peak) ? w_lvl : r_peak;
    w_quiet_next = (w_lvl < LVL_W'(END_LVL)) ? (r_quiet_cnt + 1'b1) : '0;
    w_swing_next = r_swing_cnt + 1'b1;
    w_cd_next    = r_cd_cnt + 1'b1;
  end

  // Shot sequencing FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_peak       <= '0;
      r_quiet_cnt  <= '0;
      r_swing_cnt  <= '0;
      r_cd_cnt     <= '0;
      r_shot_valid <= 1'b0;
      r_shot_power <= '0;
      r_timeout    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (shot_if.arm) begin
            r_state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          // Disarm beats a start sample arriving in the same cycle
          if (!shot_if.arm) begin
            r_state <= ST_IDLE;
          end else if (shot_if.level_valid && (w_lvl >= LVL_W'(START_LVL))) begin
            r_state     <= ST_SWING;
            r_peak      <= w_lvl;
            r_quiet_cnt <= '0;
            r_swing_cnt <= SW'(1);
            r_timeout   <= 1'b0;
          end
        end
        ST_SWING: begin
          // Once started, the swing always completes regardless of arm
          if (shot_if.level_valid) begin
            r_peak      <= w_peak_next;
            r_quiet_cnt <= w_quiet_next;
            r_swing_cnt <= w_swing_next;
            if (w_quiet_next == QW'(QUIET_SAMPLES)) begin
              r_state      <= ST_HOLD;
              r_shot_valid <= 1'b1;
              r_shot_power <= w_peak_next;
            end else if (w_swing_next == SW'(MAX_SWING)) begin
              r_state      <= ST_HOLD;
              r_shot_valid <= 1'b1;
              r_shot_power <= w_peak_next;
              r_timeout    <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (shot_if.shot_ack && r_shot_valid) begin
            r_state      <= ST_COOLDOWN;
            r_shot_valid <= 1'b0;
            r_cd_cnt     <= '0;
          end
        end
        ST_COOLDOWN: begin
          if (shot_if.level_valid) begin
            r_cd_cnt <= w_cd_next;
            if (w_cd_next == CW'(COOLDOWN_SAMPLES)) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign shot_if.sample_en  = w_sample_en;
  assign shot_if.shot_valid = r_shot_valid;
  assign shot_if.shot_power = r_shot_power;
  assign shot_if.state      = r_state;
  assign shot_if.timeout    = r_timeout;

endmodule

// File: tb/tb_cue_shot_controller.sv
// tb/tb_cue_shot_controller.sv - directed self-checking bench for cue_shot_controller
module tb_cue_shot_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cue_shot_controller_if bus ();

  cue_shot_controller #(
    .SAMPLE_DIV      (9),
    .START_LVL       (4),
    .END_LVL         (2),
    .QUIET_SAMPLES   (3),
    .MAX_SWING       (32),
    .COOLDOWN_SAMPLES(16),
    .MAX_LVL         (11)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .shot_if(bus)
  );

  typedef struct {
    logic       arm;
    logic       lv;
    logic [4:0] lvl;
    logic       ack;
    int         st;
    int         vld;
    int         pwr;
    int         to;
  } vec_t;

  vec_t tbl[11];

  int checks = 0;
  int errors = 0;

  function automatic vec_t mk(input logic a, input logic v, input logic [4:0] l, input logic k,
                              input int st, input int vld, input int pwr, input int to);
    vec_t r;
    r.arm = a; r.lv = v; r.lvl = l; r.ack = k;
    r.st = st; r.vld = vld; r.pwr = pwr; r.to = to;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic v, input logic [4:0] l, input logic k);
    bus.arm         = a;
    bus.level_valid = v;
    bus.speed_level = l;
    bus.shot_ack    = k;
  endtask

  task automatic outs(input string tag, input int st, input int vld, input int pwr, input int to);
    chk({tag, " state"}, int'(bus.state), st);
    chk({tag, " shot_valid"}, int'(bus.shot_valid), vld);
    chk({tag, " shot_power"}, int'(bus.shot_power), pwr);
    chk({tag, " timeout"}, int'(bus.timeout), to);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Normal shot: 1 (ignored), 5 starts, peak 11, three quiet 1s end it
    tbl[0]  = mk(1, 0, 5'd0,  0, 1, 0, 0,  0);
    tbl[1]  = mk(1, 1, 5'd1,  0, 1, 0, 0,  0);
    tbl[2]  = mk(1, 1, 5'd5,  0, 2, 0, 0,  0);
    tbl[3]  = mk(1, 1, 5'd8,  0, 2, 0, 0,  0);
    tbl[4]  = mk(1, 1, 5'd11, 0, 2, 0, 0,  0);
    tbl[5]  = mk(1, 0, 5'd0,  0, 2, 0, 0,  0);
    tbl[6]  = mk(1, 1, 5'd6,  0, 2, 0, 0,  0);
    tbl[7]  = mk(1, 1, 5'd1,  0, 2, 0, 0,  0);
    tbl[8]  = mk(1, 1, 5'd1,  0, 2, 0, 0,  0);
    tbl[9]  = mk(1, 1, 5'd1,  0, 3, 1, 11, 0);
    tbl[10] = mk(1, 0, 5'd0,  0, 3, 1, 11, 0);

    // Reset state and divider cadence
    drive(0, 0, 5'd0, 0);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    outs("reset", 0, 0, 0, 0);
    chk("reset sample_en", int'(bus.sample_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 28; k++) begin
      cyc();
      chk($sformatf("divider cycle %0d sample_en", k), int'(bus.sample_en), (k % 9 == 0) ? 1 : 0);
      if (k < 9) outs($sformatf("pre-strobe %0d", k), 0, 0, 0, 0);
    end

    // Normal shot from the vector table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].arm, tbl[i].lv, tbl[i].lvl, tbl[i].ack);
      cyc();
      outs($sformatf("vec %0d", i), tbl[i].st, tbl[i].vld, tbl[i].pwr, tbl[i].to);
    end

    // Handshake: output held while unacknowledged, then ack releases it
    drive(1, 0, 5'd0, 0);
    for (int i = 0; i < 20; i++) begin
      cyc();
      outs($sformatf("hold wait %0d", i), 3, 1, 11, 0);
    end
    drive(1, 0, 5'd0, 1);
    cyc();
    outs("after ack", 4, 0, 11, 0);
    drive(1, 0, 5'd0, 1);
    cyc();
    outs("ack ignored in cooldown", 4, 0, 11, 0);

    // Cooldown counts 16 level strobes, then re-arms since arm is still high
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 5'd11, 0);
      cyc();
      chk($sformatf("cooldown strobe %0d state", i + 1), int'(bus.state), (i == 15) ? 0 : 4);
      drive(1, 0, 5'd0, 0);
      cyc();
    end
    outs("rearm", 1, 0, 11, 0);

    // Timeout with clamp: 20 clamps to 11, then 31 non-quiet samples
    drive(1, 1, 5'd20, 0);
    cyc();
    outs("timeout start", 2, 0, 11, 0);
    for (int j = 2; j <= 32; j++) begin
      drive(1, 1, 5'd6, 0);
      cyc();
      if (j == 31) outs("timeout sample 31", 2, 0, 11, 0);
      if (j == 32) outs("timeout sample 32", 3, 1, 11, 1);
    end
    drive(1, 0, 5'd0, 1);
    cyc();
    outs("timeout ack", 4, 0, 11, 1);
    for (int i = 0; i < 16; i++) begin
      drive(1, 1, 5'd6, 0);
      cyc();
    end
    drive(1, 0, 5'd0, 0);
    cyc();
    outs("timeout rearm", 1, 0, 11, 1);

    // Disarm and start gating
    drive(1, 1, 5'd3, 0);
    cyc();
    chk("below start level state", int'(bus.state), 1);
    drive(0, 0, 5'd0, 0);
    cyc();
    chk("disarm state", int'(bus.state), 0);
    drive(1, 0, 5'd0, 0);
    cyc();
    chk("arm again state", int'(bus.state), 1);
    drive(0, 1, 5'd9, 0);
    cyc();
    chk("disarm beats start state", int'(bus.state), 0);

    // Swing entry clears timeout; async reset mid-swing drops the shot
    drive(1, 0, 5'd0, 0);
    cyc();
    chk("armed before swing", int'(bus.state), 1);
    drive(1, 1, 5'd9, 0);
    cyc();
    outs("swing entry", 2, 0, 11, 0);
    drive(1, 1, 5'd10, 0);
    cyc();
    chk("mid swing state", int'(bus.state), 2);
    drive(1, 1, 5'd1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    outs("async reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk($sformatf("post reset %0d shot_valid", i), int'(bus.shot_valid), 0);
    end
    outs("post reset final", 1, 0, 0, 0);
    drive(0, 0, 5'd0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
